// File: rtl/lsu_misalign_unit_if.sv
// Core-side request/response and data-memory signals of the load/store front-end.
// The slave modport is the unit; the master modport is the core plus memory environment.
interface lsu_misalign_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
        output stall, resp_valid, resp_data, mem_write, mem_addr, mem_wdata, mem_funct3
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
        input  stall, resp_valid, resp_data, mem_write, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/lsu_misalign_unit.sv
// Load/store front-end: aligned accesses pass straight through, misaligned loads become two
// word reads merged and extended, misaligned stores become a run of byte writes.
module lsu_misalign_unit (
    input logic                clk,
    input logic                rst,
    lsu_misalign_unit_if.slave io_bus
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_LD_HI   = 2'b01;
    localparam logic [1:0] ST_ST_BYTE = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_lo;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_capture;
    logic        w_req_misaligned;
    logic        w_last_byte;
    logic [31:0] w_ld_hi_addr;
    logic [31:0] w_st_addr;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return (a != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Low-order bytes of {hi,lo} starting at the byte offset, then sized and extended.
    function automatic logic [31:0] merge_load(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] v_cat;
        v_cat = 32'({hi, lo} >> {off, 3'b000});
        case (f3)
            F3_H:    return {{16{v_cat[15]}}, v_cat[15:0]};
            F3_HU:   return {16'h0000, v_cat[15:0]};
            default: return v_cat;
        endcase
    endfunction

    assign w_req_misaligned = is_misaligned(io_bus.req_funct3, io_bus.req_addr[1:0]);
    assign w_last_byte      = (r_cnt == ((r_funct3 == F3_W) ? 2'd3 : 2'd1));
    assign w_ld_hi_addr     = {r_addr[31:2], 2'b00} + 32'd4;
    assign w_st_addr        = r_addr + {30'd0, r_cnt};

    // Next-state and all memory/core outputs; the idle path is purely combinational.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_capture         = 1'b0;
        io_bus.stall      = 1'b0;
        io_bus.resp_valid = 1'b0;
        io_bus.resp_data  = io_bus.mem_rdata;
        io_bus.mem_write  = 1'b0;
        io_bus.mem_addr   = io_bus.req_addr;
        io_bus.mem_wdata  = io_bus.req_wdata;
        io_bus.mem_funct3 = io_bus.req_funct3;
        if (!rst) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req_valid && w_req_misaligned && io_bus.req_write) begin
                        io_bus.mem_wdata  = {24'd0, io_bus.req_wdata[7:0]};
                        io_bus.mem_funct3 = F3_B;
                        io_bus.mem_write  = 1'b1;
                        io_bus.stall      = 1'b1;
                        w_capture         = 1'b1;
                        w_cnt_nxt         = 2'd1;
                        w_state_nxt       = ST_ST_BYTE;
                    end else if (io_bus.req_valid && w_req_misaligned) begin
                        io_bus.mem_addr   = {io_bus.req_addr[31:2], 2'b00};
                        io_bus.mem_funct3 = F3_W;
                        io_bus.stall      = 1'b1;
                        w_capture         = 1'b1;
                        w_state_nxt       = ST_LD_HI;
                    end else if (io_bus.req_valid) begin
                        io_bus.mem_write  = io_bus.req_write;
                        io_bus.resp_valid = ~io_bus.req_write;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LD_HI: begin
                    io_bus.mem_addr   = w_ld_hi_addr;
                    io_bus.mem_wdata  = r_wdata;
                    io_bus.mem_funct3 = F3_W;
                    io_bus.resp_data  = merge_load(io_bus.mem_rdata, r_lo, r_addr[1:0], r_funct3);
                    io_bus.resp_valid = 1'b1;
                    w_state_nxt       = ST_IDLE;
                end
                ST_ST_BYTE: begin
                    io_bus.mem_addr   = w_st_addr;
                    io_bus.mem_wdata  = {24'd0, r_wdata[{r_cnt, 3'b000} +: 8]};
                    io_bus.mem_funct3 = F3_B;
                    io_bus.mem_write  = 1'b1;
                    io_bus.stall      = ~w_last_byte;
                    if (w_last_byte) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 2'd1;
                        w_state_nxt = ST_ST_BYTE;
                    end
                end
                default: begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, byte counter and the request snapshot taken when a split access starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_addr   <= io_bus.req_addr;
                r_wdata  <= io_bus.req_wdata;
                r_funct3 <= io_bus.req_funct3;
                r_lo     <= io_bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_misalign_unit.sv
// Scoreboard bench for lsu_misalign_unit: directed cases plus random loads/stores against a
// byte-array reference model; a negedge monitor checks every response and memory write.
module tb_lsu_misalign_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic do_init = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] exp_resp[$];
    wr_t         exp_wr[$];
    wr_t         mon_e;

    logic [7:0] dut_mem [4096];
    logic [7:0] ref_mem [4096];
    logic [31:0] rd_w;
    logic [31:0] rd_sh;
    logic [11:0] rd_a;

    localparam logic [9:0]  IIDX [4] = '{10'd0, 10'd1, 10'd2, 10'd1023};
    localparam logic [31:0] IW   [4] = '{32'h44332211, 32'h88776655, 32'h000000AA, 32'h11223344};

    always #5 clk = ~clk;

    lsu_misalign_unit_if bus();

    lsu_misalign_unit dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Data memory: 4 KB, combinational read with size/sign select.
    always_comb begin
        rd_a  = {bus.mem_addr[11:2], 2'b00};
        rd_w  = {dut_mem[rd_a + 12'd3], dut_mem[rd_a + 12'd2], dut_mem[rd_a + 12'd1], dut_mem[rd_a]};
        rd_sh = rd_w >> {bus.mem_addr[1:0], 3'b000};
        case (bus.mem_funct3)
            3'b000:  bus.mem_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b100:  bus.mem_rdata = {24'd0, rd_sh[7:0]};
            3'b001:  bus.mem_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b101:  bus.mem_rdata = {16'd0, rd_sh[15:0]};
            default: bus.mem_rdata = rd_w;
        endcase
    end

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 4096; i++) dut_mem[i] <= 8'h00;
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < 4; b++)
                    dut_mem[{IIDX[k], 2'(b)}] <= IW[k][8*b +: 8];
        end else if (bus.mem_write) begin
            dut_mem[bus.mem_addr[11:0]] <= bus.mem_wdata[7:0];
            if (bus.mem_funct3[1:0] != 2'b00)
                dut_mem[bus.mem_addr[11:0] + 12'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_funct3[1:0] == 2'b10) begin
                dut_mem[bus.mem_addr[11:0] + 12'd2] <= bus.mem_wdata[23:16];
                dut_mem[bus.mem_addr[11:0] + 12'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: every load response and every memory write is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got %08h expected no response", bus.resp_data);
                end else begin
                    check("resp_data", bus.resp_data, exp_resp.pop_front());
                end
            end
            if (bus.mem_write) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write @%08h expected none", bus.mem_addr);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", bus.mem_addr, mon_e.addr);
                    check("wr_data", bus.mem_wdata, mon_e.data);
                    check("wr_funct3", {29'd0, bus.mem_funct3}, {29'd0, mon_e.f3});
                end
            end
        end
    end

    task automatic ref_init();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                ref_mem[{IIDX[k], 2'(b)}] = IW[k][8*b +: 8];
    endtask

    task automatic init_mem();
        do_init = 1'b1;
        @(posedge clk); #1;
        do_init = 1'b0;
        ref_init();
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int size, input bit uns);
        logic [31:0] v, a_k;
        v = 32'd0;
        for (int k = 0; k < size; k++) begin
            a_k = addr + 32'(k);
            v = v | (32'(ref_mem[a_k[11:0]]) << (8 * k));
        end
        if (!uns && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                               input bit mis, input int size);
        wr_t e;
        logic [31:0] a_k;
        if (!mis) begin
            e.addr = addr; e.data = wdata; e.f3 = f3;
            exp_wr.push_back(e);
        end
        for (int k = 0; k < size; k++) begin
            a_k = addr + 32'(k);
            ref_mem[a_k[11:0]] = wdata[8*k +: 8];
            if (mis) begin
                e.addr = a_k; e.data = {24'd0, wdata[8*k +: 8]}; e.f3 = 3'b000;
                exp_wr.push_back(e);
            end
        end
    endtask

    // One core request held until stall drops; checks cycle count and load read addresses.
    task automatic do_op(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input bit has_exp, input logic [31:0] exp_v);
        int size, exp_cyc, cyc;
        bit mis;
        logic [31:0] base;
        size    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        mis     = (addr & 32'(size - 1)) != 32'd0;
        base    = addr & 32'hFFFF_FFFC;
        exp_cyc = !mis ? 1 : (w ? size : 2);
        if (w) model_store(addr, wdata, f3, mis, size);
        else   exp_resp.push_back(has_exp ? exp_v : model_load(addr, size, f3[2]));
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_funct3 = f3;
        cyc = 0;
        while (cyc < 8) begin
            @(negedge clk);
            if (!w) check("rd_addr", bus.mem_addr, !mis ? addr : ((cyc == 0) ? base : base + 32'd4));
            cyc++;
            if (!bus.stall) break;
            @(posedge clk); #1;
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            bus.req_funct3 = 3'($urandom_range(0, 7));
        end
        check("cycles", 32'(cyc), 32'(exp_cyc));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  lf3 [5];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        w;
        int          bad, r;
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'd0;
        bus.req_wdata = 32'h1234_5678; bus.req_funct3 = 3'b010;
        init_mem();
        @(negedge clk);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        bus.req_write = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 32'h4,   32'd0, 3'b010, 1'b1, 32'h88776655);
        do_op(1'b0, 32'h1,   32'd0, 3'b010, 1'b1, 32'h55443322);
        do_op(1'b0, 32'h7,   32'd0, 3'b001, 1'b1, 32'hFFFFAA88);
        do_op(1'b0, 32'h7,   32'd0, 3'b101, 1'b1, 32'h0000AA88);
        do_op(1'b0, 32'h6,   32'd0, 3'b001, 1'b1, 32'hFFFF8877);
        do_op(1'b0, 32'hFFF, 32'd0, 3'b010, 1'b1, 32'h33221111);
        do_op(1'b1, 32'h2,   32'hDEADBEEF, 3'b010, 1'b0, 32'd0);
        do_op(1'b0, 32'h0,   32'd0, 3'b010, 1'b1, 32'hBEEF2211);
        do_op(1'b0, 32'h4,   32'd0, 3'b010, 1'b1, 32'h8877DEAD);

        // Reset lands after the first byte of a split halfword store.
        init_mem();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h3;
        bus.req_wdata = 32'h0000CAFE; bus.req_funct3 = 3'b001;
        mon_e.addr = 32'h3; mon_e.data = 32'h0000_00FE; mon_e.f3 = 3'b000;
        exp_wr.push_back(mon_e);
        ref_mem[3] = 8'hFE;
        @(negedge clk);
        check("abort_stall_first", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_addr = 32'h0; bus.req_funct3 = 3'b010;
        @(negedge clk);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        do_op(1'b0, 32'h0, 32'd0, 3'b010, 1'b1, 32'hFE332211);
        do_op(1'b0, 32'h4, 32'd0, 3'b010, 1'b1, 32'h88776655);

        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 2) == 0);
            f3 = w ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            r  = $urandom_range(0, 5);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else if (r == 2) addr = 32'h0000_0FF0 + 32'($urandom_range(0, 15));
            else             addr = 32'($urandom_range(0, 4095));
            do_op(w, addr, $urandom, f3, 1'b0, 32'd0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        check("mem_image_bad_bytes", 32'(bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
